// File: rtl/mc_control_unit.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB/BRANCH and drives datapath selects/enables.
// Latency 3-5 cycles per instruction plus one per Mem_Ready=0 cycle; memory waits are bounded by WAIT_MAX before ERROR.
module mc_control_unit #(
  parameter int OPC_W    = 6,
  parameter int FUNC_W   = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic [31:0]       Instr,
  input  logic              ALU_zero,
  input  logic              Mem_Ready,
  output logic              PC_Sel,
  output logic              PC_LdEn,
  output logic              IR_LdEn,
  output logic              Sel_Instr,
  output logic              Mem_RdEn,
  output logic              Mem_WrEn,
  output logic              RF_WrEn,
  output logic              RF_WrData_sel,
  output logic              RF_B_sel,
  output logic              ALU_Bin_sel,
  output logic [FUNC_W-1:0] ALU_func,
  output logic              Busy,
  output logic              Error
);

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_BRANCH,
    ST_ERROR
  } state_t;

  localparam logic [OPC_W-1:0]  OP_RTYPE = OPC_W'(6'b100000);
  localparam logic [OPC_W-1:0]  OP_ADDI  = OPC_W'(6'b110000);
  localparam logic [OPC_W-1:0]  OP_LW    = OPC_W'(6'b001111);
  localparam logic [OPC_W-1:0]  OP_SW    = OPC_W'(6'b011111);
  localparam logic [OPC_W-1:0]  OP_BEQ   = OPC_W'(6'b000000);
  localparam logic [OPC_W-1:0]  OP_B     = OPC_W'(6'b111111);
  localparam logic [FUNC_W-1:0] ALU_ADD  = FUNC_W'(4'b0000);
  localparam logic [FUNC_W-1:0] ALU_SUB  = FUNC_W'(4'b0001);
  localparam logic [7:0]        WAIT_LIM = 8'(WAIT_MAX);

  state_t     r_state;
  state_t     w_next;
  logic       r_run;
  logic [7:0] r_wait_cnt;

  logic [OPC_W-1:0] w_opc;
  logic w_is_rtype, w_is_addi, w_is_lw, w_is_sw, w_is_beq, w_is_b;
  logic w_legal, w_wait_done, w_waiting, w_take;
  logic w_unused_instr;

  assign w_opc      = Instr[31 -: OPC_W];
  assign w_is_rtype = (w_opc == OP_RTYPE);
  assign w_is_addi  = (w_opc == OP_ADDI);
  assign w_is_lw    = (w_opc == OP_LW);
  assign w_is_sw    = (w_opc == OP_SW);
  assign w_is_beq   = (w_opc == OP_BEQ);
  assign w_is_b     = (w_opc == OP_B);
  assign w_legal    = w_is_rtype | w_is_addi | w_is_lw | w_is_sw | w_is_beq | w_is_b;
  assign w_take     = w_is_b | (w_is_beq & ALU_zero);
  assign w_unused_instr = ^Instr;

  // Ready on the cycle the count reaches the limit still counts as success.
  assign w_wait_done = (r_wait_cnt == WAIT_LIM);
  assign w_waiting   = !Mem_Ready && ((r_state == ST_FETCH && r_run) || r_state == ST_MEM);

  // r_run holds off the first fetch for one idle cycle after reset release.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      r_state    <= ST_FETCH;
      r_run      <= 1'b0;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
      if (w_next != r_state)
        r_wait_cnt <= 8'd0;
      else if (w_waiting)
        r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  always_comb begin
    w_next        = r_state;
    PC_Sel        = 1'b0;
    PC_LdEn       = 1'b0;
    IR_LdEn       = 1'b0;
    Sel_Instr     = 1'b0;
    Mem_RdEn      = 1'b0;
    Mem_WrEn      = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = ALU_ADD;
    Busy          = 1'b0;
    Error         = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (r_run) begin
          Busy      = 1'b1;
          Sel_Instr = 1'b1;
          Mem_RdEn  = 1'b1;
          if (Mem_Ready) begin
            IR_LdEn = 1'b1;
            PC_LdEn = 1'b1;
            w_next  = ST_DECODE;
          end else if (w_wait_done) begin
            w_next = ST_ERROR;
          end
        end
      end
      ST_DECODE: begin
        Busy = 1'b1;
        if (!w_legal)
          w_next = ST_ERROR;
        else if (w_is_b || w_is_beq)
          w_next = ST_BRANCH;
        else
          w_next = ST_EXEC;
      end
      ST_EXEC: begin
        Busy        = 1'b1;
        ALU_func    = w_is_rtype ? Instr[FUNC_W-1:0] : ALU_ADD;
        ALU_Bin_sel = w_is_addi | w_is_lw | w_is_sw;
        w_next      = (w_is_lw || w_is_sw) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        Busy     = 1'b1;
        Mem_RdEn = w_is_lw;
        Mem_WrEn = w_is_sw;
        if (Mem_Ready)
          w_next = w_is_lw ? ST_WB : ST_FETCH;
        else if (w_wait_done)
          w_next = ST_ERROR;
      end
      ST_WB: begin
        Busy          = 1'b1;
        RF_WrEn       = 1'b1;
        RF_WrData_sel = w_is_lw;
        RF_B_sel      = w_is_rtype;
        w_next        = ST_FETCH;
      end
      ST_BRANCH: begin
        Busy     = 1'b1;
        ALU_func = ALU_SUB;
        PC_LdEn  = w_take;
        PC_Sel   = w_take;
        w_next   = ST_FETCH;
      end
      ST_ERROR: begin
        Busy  = 1'b1;
        Error = 1'b1;
      end
      default: begin
        w_next = ST_ERROR;
      end
    endcase
  end

  a_rd_wr_excl: assert property (@(posedge clock) disable iff (!Reset)
    !(Mem_RdEn && Mem_WrEn));
  a_err_quiet: assert property (@(posedge clock) disable iff (!Reset)
    Error |-> !(PC_LdEn || IR_LdEn || Mem_RdEn || Mem_WrEn || RF_WrEn));

endmodule

// File: tb/tb_mc_control_unit.sv
// Cycle-accurate scoreboard bench for mc_control_unit: expected output words are queued per instruction and compared each cycle.
module tb_mc_control_unit;

  logic        clock = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] Instr = 32'd0;
  logic        ALU_zero = 1'b0;
  logic        Mem_Ready = 1'b0;
  logic        PC_Sel, PC_LdEn, IR_LdEn, Sel_Instr, Mem_RdEn, Mem_WrEn;
  logic        RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel, Busy, Error;
  logic [3:0]  ALU_func;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_ILL   = 6'b010101;

  typedef struct packed {
    logic       pc_sel;
    logic       pc_ld;
    logic       ir_ld;
    logic       sel_instr;
    logic       rd;
    logic       wr;
    logic       rf_we;
    logic       rf_wd_sel;
    logic       rf_b_sel;
    logic       bin_sel;
    logic [3:0] func;
    logic       busy;
    logic       err;
  } out_t;

  out_t exp_q[$];
  logic rdy_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  mc_control_unit #(.OPC_W(6), .FUNC_W(4), .WAIT_MAX(3)) dut (
    .clock(clock), .Reset(Reset), .Instr(Instr), .ALU_zero(ALU_zero), .Mem_Ready(Mem_Ready),
    .PC_Sel(PC_Sel), .PC_LdEn(PC_LdEn), .IR_LdEn(IR_LdEn), .Sel_Instr(Sel_Instr),
    .Mem_RdEn(Mem_RdEn), .Mem_WrEn(Mem_WrEn), .RF_WrEn(RF_WrEn), .RF_WrData_sel(RF_WrData_sel),
    .RF_B_sel(RF_B_sel), .ALU_Bin_sel(ALU_Bin_sel), .ALU_func(ALU_func), .Busy(Busy), .Error(Error)
  );

  function automatic out_t observed();
    out_t o;
    o.pc_sel = PC_Sel;     o.pc_ld = PC_LdEn;        o.ir_ld = IR_LdEn;
    o.sel_instr = Sel_Instr; o.rd = Mem_RdEn;        o.wr = Mem_WrEn;
    o.rf_we = RF_WrEn;     o.rf_wd_sel = RF_WrData_sel; o.rf_b_sel = RF_B_sel;
    o.bin_sel = ALU_Bin_sel; o.func = ALU_func;      o.busy = Busy; o.err = Error;
    return o;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input out_t o, input logic rdy);
    exp_q.push_back(o);
    rdy_q.push_back(rdy);
  endtask

  function automatic out_t busy_only();
    out_t o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  task automatic push_fetch(input int waits);
    out_t o = busy_only();
    o.sel_instr = 1'b1;
    o.rd = 1'b1;
    for (int i = 0; i < waits; i++) push(o, 1'b0);
    o.ir_ld = 1'b1;
    o.pc_ld = 1'b1;
    push(o, 1'b1);
  endtask

  task automatic push_error(input int cycles);
    out_t o = busy_only();
    o.err = 1'b1;
    for (int i = 0; i < cycles; i++) push(o, 1'($urandom_range(0, 1)));
  endtask

  // Drive one queued cycle per falling edge and compare the settled outputs.
  task automatic run_trace(input string tag, input logic zero);
    int   c = 0;
    out_t o;
    logic r;
    while (exp_q.size() > 0) begin
      o = exp_q.pop_front();
      r = rdy_q.pop_front();
      @(negedge clock);
      Mem_Ready = r;
      ALU_zero  = zero;
      #1;
      check_eq($sformatf("%s_c%0d", tag, c), 32'(observed()), 32'(o));
      c++;
    end
  endtask

  // Queue the full expected trace of one instruction, then run it.
  task automatic do_instr(input string tag, input logic [5:0] opc, input logic [3:0] fn,
                          input int fw, input int mw, input logic zero);
    out_t o;
    Instr = {opc, 22'($urandom), fn};
    push_fetch(fw);
    push(busy_only(), 1'($urandom_range(0, 1)));
    case (opc)
      OP_RTYPE, OP_ADDI, OP_LW, OP_SW: begin
        o = busy_only();
        o.func    = (opc == OP_RTYPE) ? fn : 4'b0000;
        o.bin_sel = (opc != OP_RTYPE);
        push(o, 1'($urandom_range(0, 1)));
        if (opc == OP_LW || opc == OP_SW) begin
          o = busy_only();
          o.rd = (opc == OP_LW);
          o.wr = (opc == OP_SW);
          for (int i = 0; i < mw; i++) push(o, 1'b0);
          push(o, 1'b1);
        end
        if (opc != OP_SW) begin
          o = busy_only();
          o.rf_we     = 1'b1;
          o.rf_wd_sel = (opc == OP_LW);
          o.rf_b_sel  = (opc == OP_RTYPE);
          push(o, 1'($urandom_range(0, 1)));
        end
      end
      OP_BEQ, OP_B: begin
        o = busy_only();
        o.func   = 4'b0001;
        o.pc_ld  = (opc == OP_B) || zero;
        o.pc_sel = (opc == OP_B) || zero;
        push(o, 1'($urandom_range(0, 1)));
      end
      default: push_error(3);
    endcase
    run_trace(tag, zero);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    Reset = 1'b0;
    #1;
    check_eq({tag, "_in_reset"}, 32'(observed()), 32'd0);
    @(negedge clock);
    Reset = 1'b1;
    #1;
    check_eq({tag, "_idle"}, 32'(observed()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    out_t o;
    #2;
    check_eq("reset_state", 32'(observed()), 32'd0);
    @(negedge clock);
    Reset = 1'b1;
    #1;
    check_eq("idle_after_reset", 32'(observed()), 32'd0);

    do_instr("rtype_sub", OP_RTYPE, 4'b0001, 0, 0, 1'b0);
    do_instr("addi",      OP_ADDI,  4'b1010, 1, 0, 1'b1);
    do_instr("lw_w3",     OP_LW,    4'b0110, 0, 3, 1'b0);
    do_instr("sw_f2m1",   OP_SW,    4'b1111, 2, 1, 1'b1);
    do_instr("beq_taken", OP_BEQ,   4'b0000, 0, 0, 1'b1);
    do_instr("beq_not",   OP_BEQ,   4'b0011, 0, 0, 1'b0);
    do_instr("b_always",  OP_B,     4'b0101, 0, 0, 1'b0);
    do_instr("rtype_f3",  OP_RTYPE, 4'b1001, 3, 0, 1'b1);

    // Reset while a store is waiting in MEM must drop the write at once.
    Instr = {OP_SW, 22'($urandom), 4'b0000};
    push_fetch(0);
    push(busy_only(), 1'b1);
    o = busy_only();
    o.bin_sel = 1'b1;
    push(o, 1'b1);
    o = busy_only();
    o.wr = 1'b1;
    push(o, 1'b0);
    run_trace("sw_abort", 1'b0);
    #1;
    Reset = 1'b0;
    #1;
    check_eq("abort_wren", 32'(Mem_WrEn), 32'd0);
    check_eq("abort_outputs", 32'(observed()), 32'd0);
    @(negedge clock);
    Reset = 1'b1;
    #1;
    check_eq("abort_idle", 32'(observed()), 32'd0);
    do_instr("after_abort", OP_RTYPE, 4'b0001, 0, 0, 1'b0);

    do_instr("illegal", OP_ILL, 4'b0001, 0, 0, 1'b0);
    do_reset("after_illegal");
    do_instr("post_illegal", OP_ADDI, 4'b0000, 0, 0, 1'b0);

    Instr = {OP_RTYPE, 22'd0, 4'b0000};
    o = busy_only();
    o.sel_instr = 1'b1;
    o.rd = 1'b1;
    for (int i = 0; i < 4; i++) push(o, 1'b0);
    push_error(4);
    run_trace("fetch_timeout", 1'b0);
    do_reset("after_fetch_to");

    Instr = {OP_LW, 22'd0, 4'b0000};
    push_fetch(0);
    push(busy_only(), 1'b1);
    o = busy_only();
    o.bin_sel = 1'b1;
    push(o, 1'b1);
    o = busy_only();
    o.rd = 1'b1;
    for (int i = 0; i < 4; i++) push(o, 1'b0);
    push_error(3);
    run_trace("mem_timeout", 1'b0);
    do_reset("after_mem_to");

    do_instr("final_lw", OP_LW, 4'b0000, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle control unit for the processor: a parametrised successor to the single-cycle CONTROL block. It sequences every instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the existing Datapath select and enable signals. Instruction and data memory accesses use a variable-latency ready handshake with a bounded wait. It sits between the PROCESSOR top and the Datapath, with a new instruction-register load enable.

## Interface
- `OPC_W`, default 6: opcode width, taken from `Instr[31:32-OPC_W]`.
- `FUNC_W`, default 4: R-type function width, taken from `Instr[FUNC_W-1:0]`. Drives `ALU_func` directly.
- `WAIT_MAX`, default 15: maximum wait cycles for `Mem_Ready` before entering ERROR. Range 1..255.

Ports:
- `clock` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `Instr` in 32: instruction-register contents from the Datapath.
- `ALU_zero` in 1: ALU zero flag.
- `Mem_Ready` in 1: memory access complete. Sampled in FETCH and MEM.
- `PC_Sel` out 1: 0 = PC+4, 1 = branch target.
- `PC_LdEn` out 1: PC load, one-cycle pulse.
- `IR_LdEn` out 1: instruction-register load, one-cycle pulse.
- `Sel_Instr` out 1: 1 = memory port addressed by PC.
- `Mem_RdEn` out 1: memory read request.
- `Mem_WrEn` out 1: memory write request.
- `RF_WrEn` out 1: register-file write, one-cycle pulse.
- `RF_WrData_sel` out 1: 0 = ALU result, 1 = memory data.
- `RF_B_sel` out 1: 0 = rt field, 1 = rd field.
- `ALU_Bin_sel` out 1: 0 = register, 1 = immediate.
- `ALU_func` out `FUNC_W`: ALU operation.
- `Busy` out 1: 1 in every state except FETCH-idle after reset.
- `Error` out 1: sticky. Set on timeout or illegal opcode.

## Operation
- State register encodings: FETCH, DECODE, EXEC, MEM, WB, BRANCH, ERROR.
- Opcodes, with `OPC_W` = 6:
  - RTYPE `6'b100000`
  - ADDI `6'b110000`
  - LW `6'b001111`
  - SW `6'b011111`
  - BEQ `6'b000000`
  - B `6'b111111`
  - Any other opcode is illegal.
- ALU codes: ADD `4'b0000`, SUB `4'b0001`.
- FETCH: `Sel_Instr=1`, `Mem_RdEn=1`.
  - On `Mem_Ready`: pulse `IR_LdEn` and `PC_LdEn` with `PC_Sel=0`, then go to DECODE.
- DECODE: one cycle.
  - Illegal opcode goes to ERROR.
  - B and BEQ go to BRANCH.
  - All other opcodes go to EXEC.
- EXEC: one cycle. `ALU_func` is `Instr[FUNC_W-1:0]` for RTYPE, otherwise ADD.
  - `ALU_Bin_sel=1` for ADDI, LW and SW.
  - LW and SW go to MEM. RTYPE and ADDI go to WB.
- MEM: `Sel_Instr=0`, with `Mem_RdEn` (LW) or `Mem_WrEn` (SW) held until `Mem_Ready`.
  - LW then goes to WB. SW then goes to FETCH.
- WB: pulse `RF_WrEn`, then go to FETCH.
  - `RF_WrData_sel=1` only for LW.
  - `RF_B_sel=1` for RTYPE.
- BRANCH: `ALU_func=SUB`, `ALU_Bin_sel=0`.
  - Pulse `PC_LdEn` with `PC_Sel=1` if opcode is B, or if opcode is BEQ and `ALU_zero=1`.
  - Then go to FETCH.
- Wait counter: 8 bits, cleared on entry to FETCH or MEM.
  - Increments each cycle `Mem_Ready=0`.
  - When the count reaches `WAIT_MAX` with `Mem_Ready` still 0, go to ERROR.
- ERROR: all enables are 0 and `Error=1`. Only `Reset` exits this state.
- Only one of `Mem_RdEn` and `Mem_WrEn` is ever high in a cycle.

## Timing
- Reset (asynchronous, `Reset=0`):
  - State is FETCH, wait counter is 0.
  - All enables and selects are 0, `ALU_func=0`, `Busy=0`, `Error=0`.
  - After reset deassertion, `Busy` goes to 1 in the first FETCH cycle in which `Mem_RdEn` is asserted.
- Outputs are Moore-decoded from state and `Instr`, except two Mealy terms:
  - `IR_LdEn`/`PC_LdEn` gated by `Mem_Ready` in FETCH.
  - `PC_LdEn` gated by `ALU_zero` in BRANCH.
- Instruction latency, with `Mem_Ready` always 1:

  | Instruction | Cycles | Path |
  |---|---|---|
  | RTYPE, ADDI | 4 | F, D, E, W |
  | LW | 5 | F, D, E, M, W |
  | SW | 4 | F, D, E, M |
  | B, BEQ | 3 | F, D, BR |

  Each cycle of `Mem_Ready=0` in FETCH or MEM adds one cycle.
- `Mem_Ready` arriving on the same cycle the count reaches `WAIT_MAX` counts as success, not a timeout.
- `Reset` asserted mid-instruction aborts the instruction immediately. No `RF_WrEn` or `Mem_WrEn` is issued afterwards.
- `Instr` must be stable from DECODE to the end of the instruction. The IR is loaded only in FETCH.

## Test plan
- RTYPE sub: `Instr={6'b100000,…,4'b0001}`, `Mem_Ready=1` → 4 cycles. `ALU_func=4'b0001` in EXEC, `RF_WrEn` pulse in cycle 4 with `RF_B_sel=1`, `RF_WrData_sel=0`.
- LW with 3 wait cycles in MEM → 8 cycles total. `Mem_RdEn` high 4 cycles, `RF_WrData_sel=1` during `RF_WrEn`.
- BEQ:
  - `ALU_zero=1` → `PC_LdEn` with `PC_Sel=1` in cycle 3.
  - `ALU_zero=0` → no PC load in BRANCH.
  - Both return to FETCH in cycle 4.
- Timeout: `WAIT_MAX=3`, `Mem_Ready=0` in FETCH → `Error=1` after the 4th FETCH cycle. Outputs stay 0 until `Reset`.
- Illegal opcode `6'b010101` → ERROR after DECODE. No `RF_WrEn`, no `Mem_WrEn`.
- `Reset` asserted during SW in MEM → `Mem_WrEn` drops asynchronously. After release, FETCH with `Error=0`.
